// File: rtl/syscall_console.sv
// Console output stage for the CPU's SYSCALL catch: queues {v0, a0} requests
// and streams each a0 as eight lowercase hex digits plus a newline.
module syscall_console #(
  parameter int W_CPU = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sc_valid,
  input  logic [W_CPU-1:0] sc_v0,
  input  logic [W_CPU-1:0] sc_a0,
  output logic             sc_ready,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic             halt,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HEX  = 2'd1;
  localparam logic [1:0] NL   = 2'd2;
  localparam logic [1:0] HALT = 2'd3;

  logic [W_CPU-1:0] fifo_v0 [DEPTH];
  logic [W_CPU-1:0] fifo_a0 [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [1:0]       state;
  logic [2:0]       digit;
  logic [31:0]      shift;

  logic full, empty, halted, push, pop, tx_fire, head_exit, load_rec;

  function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h57 + {4'h0, nib};
  endfunction

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign halted    = (state == HALT);
  assign sc_ready  = ~full & ~halted & rst;
  assign push      = sc_valid & sc_ready;
  assign tx_fire   = tx_valid & tx_ready;
  // NL pops on its own handshake so consecutive records run without a bubble
  assign pop       = ~empty & ((state == IDLE) | ((state == NL) & tx_fire));
  assign head_exit = (fifo_v0[rd_ptr] == W_CPU'(10));
  assign load_rec  = pop & ~head_exit;
  assign halt      = halted;

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    if (state == HEX) begin
      tx_valid = 1'b1;
      tx_data  = nib_to_ascii(shift[31:28]);
    end else if (state == NL) begin
      tx_valid = 1'b1;
      tx_data  = 8'h0A;
    end
  end

  // Datapath storage: no reset, the control state decides what is meaningful
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_v0[wr_ptr] <= sc_v0;
      fifo_a0[wr_ptr] <= sc_a0;
    end
    if (load_rec)
      shift <= 32'(fifo_a0[rd_ptr]);
    else if ((state == HEX) && tx_fire)
      shift <= {shift[27:0], 4'h0};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= IDLE;
      digit  <= '0;
      err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (sc_valid && !sc_ready && !halted) err <= 1'b1;

      case (state)
        IDLE, NL: begin
          if (pop) begin
            if (head_exit) begin
              state <= HALT;
            end else begin
              state <= HEX;
              digit <= '0;
            end
          end else if ((state == NL) && tx_fire) begin
            state <= IDLE;
          end
        end
        HEX: begin
          if (tx_fire) begin
            digit <= digit + 1'b1;
            if (digit == 3'd7) state <= NL;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_console.sv
// Directed bench for syscall_console: framing, latency, backpressure, overflow, exit and reset.
module tb_syscall_console;

  logic        clk = 1'b0;
  logic        rst;
  logic        sc_valid;
  logic [31:0] sc_v0, sc_a0;
  logic        sc_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halt, err;

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  syscall_console #(.W_CPU(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .sc_valid(sc_valid), .sc_v0(sc_v0), .sc_a0(sc_a0),
    .sc_ready(sc_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .halt(halt), .err(err)
  );

  // Byte capture: a handshake seen mid-cycle completes at the next rising edge
  always @(negedge clk)
    if (rst && tx_valid && tx_ready) q.push_back(tx_data);

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h61 + {4'h0, n} - 8'd10;
  endfunction

  task automatic add_exp(input logic [31:0] v);
    for (int i = 7; i >= 0; i--) exp_q.push_back(hexc(v[i*4 +: 4]));
    exp_q.push_back(8'h0A);
  endtask

  task automatic do_reset();
    sc_valid = 1'b0; tx_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    q.delete(); exp_q.delete();
  endtask

  task automatic push(input logic [31:0] v0, input logic [31:0] a0, output logic acc);
    sc_valid = 1'b1; sc_v0 = v0; sc_a0 = a0;
    #2 acc = sc_ready;
    @(posedge clk); #1 sc_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; sc_valid = 1'b0; tx_ready = 1'b0; sc_v0 = '0; sc_a0 = '0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (sc_ready !== 1'b0) begin failures++; $display("FAIL reset_sc_ready_low actual=%b required=0", sc_ready); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid actual=%b required=0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data actual=%h required=00", tx_data); end
    checks++; if (halt !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_halt_err actual=%b%b required=00", halt, err); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (sc_ready !== 1'b1) begin failures++; $display("FAIL reset_sc_ready_release actual=%b required=1", sc_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic acc;
    do_reset();
    tx_ready = 1'b1;
    add_exp(32'h0000002A);
    push(32'd1, 32'h0000002A, acc);
    checks++; if (acc !== 1'b1) begin failures++; $display("FAIL single_accept actual=%b required=1", acc); end
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL single_latency_early actual=%b required=0", tx_valid); end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin
        failures++; $display("FAIL single_byte%0d actual=%b/%h required=1/%h", i, tx_valid, tx_data, exp_q[i]);
      end
    end
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL single_end_idle actual=%b required=0", tx_valid); end
  endtask

  task automatic test_backpressure();
    logic acc, pv, pr;
    logic [7:0] pd;
    int bad;
    do_reset();
    add_exp(32'h12345678);
    push(32'd1, 32'h12345678, acc);
    pv = 1'b0; pr = 1'b0; pd = 8'h00; bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1 tx_ready = (c % 4 == 0) || (c % 4 == 3);
      @(negedge clk);
      if (pv && !pr) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== pd) begin
          failures++; $display("FAIL bp_stable cyc=%0d actual=%b/%h required=1/%h", c, tx_valid, tx_data, pd);
        end
      end
      pv = tx_valid; pr = tx_ready; pd = tx_data;
    end
    #1;
    bad = (q.size() != exp_q.size()) ? 1 : 0;
    foreach (exp_q[i]) if (i < q.size() && q[i] !== exp_q[i]) bad = 1;
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_stream actual_len=%0d required_len=%0d", q.size(), exp_q.size()); end
  endtask

  task automatic test_full();
    logic acc;
    int bad;
    logic [31:0] vals[6] = '{32'h00000000, 32'h11111111, 32'h89abcdef, 32'h0000ffff, 32'ha5a5a5a5, 32'h66666666};
    do_reset();
    for (int i = 0; i < 5; i++) add_exp(vals[i]);
    for (int i = 0; i < 6; i++) begin
      push(32'd1, vals[i], acc);
      checks++;
      if (acc !== (i < 5)) begin failures++; $display("FAIL full_accept%0d actual=%b required=%b", i, acc, (i < 5)); end
    end
    @(negedge clk);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL full_err actual=%b required=1", err); end
    checks++; if (sc_ready !== 1'b0) begin failures++; $display("FAIL full_sc_ready actual=%b required=0", sc_ready); end
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_cycles(60);
    bad = (q.size() != exp_q.size()) ? 1 : 0;
    foreach (exp_q[i]) if (i < q.size() && q[i] !== exp_q[i]) bad = 1;
    checks++; if (bad != 0) begin failures++; $display("FAIL full_stream actual_len=%0d required_len=%0d", q.size(), exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic acc;
    int bad, gaps;
    do_reset();
    tx_ready = 1'b1;
    add_exp(32'h0f1e2d3c);
    add_exp(32'hb00b5a11);
    push(32'd1, 32'h0f1e2d3c, acc);
    push(32'd4, 32'hb00b5a11, acc);
    checks++; if (acc !== 1'b1) begin failures++; $display("FAIL b2b_accept actual=%b required=1", acc); end
    gaps = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1) gaps++;
    end
    checks++; if (gaps != 0) begin failures++; $display("FAIL b2b_bubbles actual=%0d required=0", gaps); end
    wait_cycles(3);
    bad = (q.size() != exp_q.size()) ? 1 : 0;
    foreach (exp_q[i]) if (i < q.size() && q[i] !== exp_q[i]) bad = 1;
    checks++; if (bad != 0) begin failures++; $display("FAIL b2b_stream actual_len=%0d required_len=%0d", q.size(), exp_q.size()); end
  endtask

  task automatic test_exit();
    logic acc;
    int bad, n;
    do_reset();
    tx_ready = 1'b1;
    add_exp(32'hDEADBEEF);
    push(32'd1, 32'hDEADBEEF, acc);
    push(32'd10, 32'd0, acc);
    checks++; if (acc !== 1'b1) begin failures++; $display("FAIL exit_accept actual=%b required=1", acc); end
    n = 0;
    while (halt !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    #1;
    checks++; if (halt !== 1'b1) begin failures++; $display("FAIL exit_halt_timeout actual=%b required=1", halt); end
    bad = (q.size() != exp_q.size()) ? 1 : 0;
    foreach (exp_q[i]) if (i < q.size() && q[i] !== exp_q[i]) bad = 1;
    checks++; if (bad != 0) begin failures++; $display("FAIL exit_stream actual_len=%0d required_len=%0d", q.size(), exp_q.size()); end
    checks++; if (sc_ready !== 1'b0) begin failures++; $display("FAIL exit_sc_ready actual=%b required=0", sc_ready); end
    push(32'd1, 32'h00000005, acc);
    checks++; if (acc !== 1'b0) begin failures++; $display("FAIL exit_late_accept actual=%b required=0", acc); end
    wait_cycles(15);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL exit_err actual=%b required=0", err); end
    checks++; if (q.size() != 9 || tx_valid !== 1'b0) begin failures++; $display("FAIL exit_silent actual_len=%0d/%b required_len=9/0", q.size(), tx_valid); end
  endtask

  task automatic test_other_code();
    logic acc;
    int bad;
    do_reset();
    tx_ready = 1'b1;
    add_exp(32'hFFFFFFFF);
    push(32'd7, 32'hFFFFFFFF, acc);
    wait_cycles(15);
    bad = (q.size() != exp_q.size()) ? 1 : 0;
    foreach (exp_q[i]) if (i < q.size() && q[i] !== exp_q[i]) bad = 1;
    checks++; if (bad != 0) begin failures++; $display("FAIL other_stream actual_len=%0d required_len=%0d", q.size(), exp_q.size()); end
    checks++; if (halt !== 1'b0) begin failures++; $display("FAIL other_no_halt actual=%b required=0", halt); end
  endtask

  task automatic test_reset_mid();
    logic acc;
    int n, bad;
    do_reset();
    tx_ready = 1'b1;
    push(32'd1, 32'h12345678, acc);
    n = 0;
    while (q.size() < 3 && n < 30) begin @(negedge clk); #1; n++; end
    checks++; if (q.size() < 3) begin failures++; $display("FAIL mid_progress actual_len=%0d required_len=3", q.size()); end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0 || halt !== 1'b0) begin failures++; $display("FAIL mid_reset_state actual=%b%b required=00", tx_valid, halt); end
    @(posedge clk); #1;
    q.delete(); exp_q.delete();
    add_exp(32'hCAFE0001);
    push(32'd1, 32'hCAFE0001, acc);
    wait_cycles(15);
    bad = (q.size() != exp_q.size()) ? 1 : 0;
    foreach (exp_q[i]) if (i < q.size() && q[i] !== exp_q[i]) bad = 1;
    checks++; if (bad != 0) begin failures++; $display("FAIL mid_clean_stream actual_len=%0d required_len=%0d", q.size(), exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_full();
    test_back_to_back();
    test_exit();
    test_other_code();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
